// File: rtl/complex_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : complex_alu_pkg
//  Purpose  : Shared widths and types for the complex ALU result path.
//             RESULT_W         - ALU result width
//             WORD_W           - serialized output word width
//             WORDS_PER_RESULT - output words per ALU result
//             state_t          - serializer FSM states
//  Revision : 1.0 - initial release
// ============================================================================
package complex_alu_pkg;

    localparam int RESULT_W         = 48;
    localparam int WORD_W           = 16;
    localparam int WORDS_PER_RESULT = 3;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

endpackage : complex_alu_pkg
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : result_fifo
//  Purpose  : Synchronous FIFO holding {error, result} entries between the
//             ALU and the word serializer.
//  Ports    : clk, rst_n           - clock, async active-low reset
//             push, wr_data        - write strobe and entry
//             pop                  - remove the head entry
//             rd_data              - head entry (driven from storage regs)
//             full, empty, level   - occupancy status
//  Revision : 1.0 - initial release
// ============================================================================
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 49
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw:0] c_depth = DEPTH[c_aw:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_level;

    // Data storage carries no reset: an entry is only read after it has
    // been written, and the consumer gates its outputs with valid.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({push, pop})
                2'b10:   r_level <= r_level + (c_aw + 1)'(1);
                2'b01:   r_level <= r_level - (c_aw + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // When full, a simultaneous push targets the head slot; the pop still
    // sees the old contents because the write lands at the same edge.
    assign rd_data = r_mem[r_rd_ptr];
    assign full    = (r_level == c_depth);
    assign empty   = (r_level == '0);
    assign level   = r_level;

endmodule : result_fifo
`default_nettype wire

// File: rtl/alu_result_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_serializer
//  Purpose  : Captures ALU results on their valid pulse, buffers them and
//             emits each one as three WORD_W words (LS word first) over a
//             valid/ready stream. Dropped results set a sticky flag.
//  Ports    : clk, rst_n                    - clock, async active-low reset
//             in_valid, in_error, in_result - ALU result pulse
//             out_data, out_valid, out_ready,
//             out_last, out_error           - word stream to the consumer
//             overflow, ovf_clear           - sticky drop flag and its clear
//             level                         - FIFO occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module alu_result_serializer #(
    parameter int DEPTH    = 4,
    parameter int RESULT_W = complex_alu_pkg::RESULT_W,
    parameter int WORD_W   = complex_alu_pkg::WORD_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_error,
    input  logic [RESULT_W-1:0]     in_result,
    output logic [WORD_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    out_error,
    output logic                    overflow,
    input  logic                    ovf_clear,
    output logic [$clog2(DEPTH):0]  level
);

    import complex_alu_pkg::*;

    localparam logic [1:0] c_last_idx = 2'(WORDS_PER_RESULT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_idx;
    logic [RESULT_W-1:0] r_shreg;
    logic                r_err;
    logic                r_overflow;

    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic                w_full;
    logic                w_empty;
    logic                w_beat;
    logic                w_send;
    logic                w_on_last;
    logic [RESULT_W:0]   w_head;
    logic [WORD_W-1:0]   w_word;

    assign w_send    = (r_state == S_SEND);
    assign w_beat    = w_send && out_ready;
    assign w_on_last = (r_idx == c_last_idx);

    // A full FIFO still takes a result when the head leaves in the same
    // cycle; only a full FIFO with no pop loses the incoming result.
    assign w_push = in_valid && (!w_full || w_pop);
    assign w_drop = in_valid && w_full && !w_pop;

    result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RESULT_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_push),
        .wr_data ({in_error, in_result}),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .level   (level)
    );

    // ------------------------------------------------------------------
    // FSM: next state and pop request
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                // Reload straight from the FIFO on the final beat so
                // consecutive results stream without a bubble.
                if (w_beat && w_on_last) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_shreg <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_shreg <= w_head[RESULT_W-1:0];
                r_err   <= w_head[RESULT_W];
                r_idx   <= '0;
            end else if (w_beat && !w_on_last) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    // Drop has priority over clear so a loss in the clearing cycle is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clear) begin
            r_overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Word select and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_word = '0;
        case (r_idx)
            2'd0:    w_word = r_shreg[WORD_W-1:0];
            2'd1:    w_word = r_shreg[2*WORD_W-1:WORD_W];
            default: w_word = r_shreg[3*WORD_W-1:2*WORD_W];
        endcase
    end

    // Outputs derive only from registers, so they stay stable while the
    // consumer stalls.
    assign out_valid = w_send;
    assign out_data  = w_send ? w_word : '0;
    assign out_last  = w_send && w_on_last;
    assign out_error = w_send && r_err;
    assign overflow  = r_overflow;

endmodule : alu_result_serializer
`default_nettype wire

// File: tb/tb_alu_result_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_serializer
//  Purpose  : Self-checking bench for alu_result_serializer. Expected words
//             are queued when a result is driven and compared as beats
//             transfer; scenario tasks check timing, level and flags.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_serializer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_error;
    logic [47:0] in_result;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        out_error;
    logic        overflow;
    logic        ovf_clear;
    logic [2:0]  level;

    int checks = 0;
    int passed = 0;

    // {last, error, data}
    logic [17:0] sb [$];
    logic [17:0] mon_exp;

    alu_result_serializer #(
        .DEPTH    (4),
        .RESULT_W (48),
        .WORD_W   (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_error  (in_error),
        .in_result (in_result),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_error (out_error),
        .overflow  (overflow),
        .ovf_clear (ovf_clear),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: a beat transfers at the next rising edge when valid and
    // ready are both high at the falling edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL beat: got unexpected word last=%0b err=%0b data=%h, required no beat",
                         out_last, out_error, out_data);
            end else begin
                mon_exp = sb.pop_front();
                if ({out_last, out_error, out_data} !== mon_exp)
                    $display("FAIL beat: got last=%0b err=%0b data=%h, required last=%0b err=%0b data=%h",
                             out_last, out_error, out_data, mon_exp[17], mon_exp[16], mon_exp[15:0]);
                else
                    passed++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] mk(input logic [7:0] i);
        mk = {8'h30, i, 8'h20, i, 8'h10, i};
    endfunction

    // Drive one ALU result for one cycle; queue its words if it should survive.
    task automatic drive_result(input logic [47:0] r, input logic e, input bit keep);
        in_valid  = 1'b1;
        in_error  = e;
        in_result = r;
        if (keep) begin
            sb.push_back({1'b0, e, r[15:0]});
            sb.push_back({1'b0, e, r[31:16]});
            sb.push_back({1'b1, e, r[47:32]});
        end
        tick();
        in_valid  = 1'b0;
        in_error  = 1'b0;
        in_result = '0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if ({out_valid, out_last, out_error, overflow} !== 4'b0000) $display("FAIL reset_flags: got %b, required 0000", {out_valid, out_last, out_error, overflow}); else passed++;
        checks++; if (out_data !== 16'h0000) $display("FAIL reset_data: got %h, required 0000", out_data); else passed++;
        checks++; if (level !== 3'd0) $display("FAIL reset_level: got %0d, required 0", level); else passed++;
        rst_n = 1'b1;
        tick();
        checks++; if ({out_valid, level} !== 4'b0000) $display("FAIL post_reset_idle: got valid=%0b level=%0d, required 0/0", out_valid, level); else passed++;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive_result(48'h0003_0002_0001, 1'b0, 1'b1);
        // cycle N+1: entry written, not yet on the output
        checks++; if (out_valid !== 1'b0) $display("FAIL single_n1_valid: got %0b, required 0", out_valid); else passed++;
        checks++; if (level !== 3'd1) $display("FAIL single_n1_level: got %0d, required 1", level); else passed++;
        tick();
        checks++; if ({out_valid, out_data} !== {1'b1, 16'h0001}) $display("FAIL single_n2_word0: got valid=%0b data=%h, required 1/0001", out_valid, out_data); else passed++;
        checks++; if (level !== 3'd0) $display("FAIL single_n2_level: got %0d, required 0", level); else passed++;
        tick();
        tick();
        checks++; if ({out_last, out_data} !== {1'b1, 16'h0003}) $display("FAIL single_n4_last: got last=%0b data=%h, required 1/0003", out_last, out_data); else passed++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL single_n5_idle: got %0b, required 0", out_valid); else passed++;
        checks++; if (sb.size() != 0) $display("FAIL single_drain: got %0d words left, required 0", sb.size()); else passed++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive_result(48'hCCCC_BBBB_AAAA, 1'b1, 1'b1);
        for (int i = 0; i < 10 && !out_valid; i++) tick();
        checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid_timeout: got %0b, required 1", out_valid); else passed++;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, out_last, out_error, out_data} !== {3'b101, 16'hAAAA})
                $display("FAIL bp_hold: got valid=%0b last=%0b err=%0b data=%h, required 1/0/1/aaaa",
                         out_valid, out_last, out_error, out_data);
            else
                passed++;
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        tick();
        checks++; if (sb.size() != 0) $display("FAIL bp_drain: got %0d words left, required 0", sb.size()); else passed++;
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        // One result moves into the shift register, so four more fill the FIFO.
        for (int i = 1; i <= 5; i++) drive_result(mk(8'(i)), i[0], 1'b1);
        checks++; if ({overflow, level} !== {1'b0, 3'd4}) $display("FAIL ovf_full: got ovf=%0b level=%0d, required 0/4", overflow, level); else passed++;
        // Drop coincides with a clear request: the drop must win.
        ovf_clear = 1'b1;
        drive_result(mk(8'd6), 1'b0, 1'b0);
        ovf_clear = 1'b0;
        checks++; if ({overflow, level} !== {1'b1, 3'd4}) $display("FAIL ovf_set: got ovf=%0b level=%0d, required 1/4", overflow, level); else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        tick();
        checks++; if (sb.size() != 0) $display("FAIL ovf_drain: got %0d words left, required 0", sb.size()); else passed++;
        checks++; if ({overflow, level} !== {1'b1, 3'd0}) $display("FAIL ovf_sticky: got ovf=%0b level=%0d, required 1/0", overflow, level); else passed++;
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %0b, required 0", overflow); else passed++;
    endtask

    task automatic test_back_to_back();
        logic exp_valid;
        logic exp_last;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid  = (c == 0) || (c == 3);
            in_error  = (c == 3);
            in_result = (c == 0) ? mk(8'h41) : ((c == 3) ? mk(8'h42) : 48'h0);
            if (c == 0 || c == 3) begin
                sb.push_back({1'b0, in_error, in_result[15:0]});
                sb.push_back({1'b0, in_error, in_result[31:16]});
                sb.push_back({1'b1, in_error, in_result[47:32]});
            end
            exp_valid = (c >= 2) && (c <= 7);
            exp_last  = (c == 4) || (c == 7);
            checks++; if (out_valid !== exp_valid) $display("FAIL b2b_valid c%0d: got %0b, required %0b", c, out_valid, exp_valid); else passed++;
            checks++; if (out_last !== exp_last) $display("FAIL b2b_last c%0d: got %0b, required %0b", c, out_last, exp_last); else passed++;
            tick();
        end
        in_valid  = 1'b0;
        in_error  = 1'b0;
        in_result = '0;
        checks++; if (sb.size() != 0) $display("FAIL b2b_drain: got %0d words left, required 0", sb.size()); else passed++;
    endtask

    task automatic test_simul_full();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) drive_result(mk(8'(8'h50 + i)), 1'b0, 1'b1);
        checks++; if (level !== 3'd4) $display("FAIL sim_fill: got level=%0d, required 4", level); else passed++;
        out_ready = 1'b1;
        tick();
        tick();
        checks++; if ({out_last, level} !== {1'b1, 3'd4}) $display("FAIL sim_final_beat: got last=%0b level=%0d, required 1/4", out_last, level); else passed++;
        drive_result(mk(8'h5A), 1'b1, 1'b1);
        checks++; if ({overflow, level} !== {1'b0, 3'd4}) $display("FAIL sim_push_pop: got ovf=%0b level=%0d, required 0/4", overflow, level); else passed++;
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        tick();
        checks++; if (sb.size() != 0) $display("FAIL sim_drain: got %0d words left, required 0", sb.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) drive_result(mk(8'(8'h60 + i)), 1'b0, i != 6);
        checks++; if (overflow !== 1'b1) $display("FAIL rst_pre_ovf: got %0b, required 1", overflow); else passed++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, overflow, level} !== 5'b0) $display("FAIL rst_mid_clear: got valid=%0b ovf=%0b level=%0d, required 0/0/0", out_valid, overflow, level); else passed++;
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        drive_result(mk(8'h77), 1'b1, 1'b1);
        tick();
        checks++; if ({out_valid, out_error, out_data} !== {2'b11, 16'h1077}) $display("FAIL rst_new_word0: got valid=%0b err=%0b data=%h, required 1/1/1077", out_valid, out_error, out_data); else passed++;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        tick();
        checks++; if (sb.size() != 0) $display("FAIL rst_drain: got %0d words left, required 0", sb.size()); else passed++;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_error  = 1'b0;
        in_result = '0;
        out_ready = 1'b0;
        ovf_clear = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_simul_full();
        test_reset_mid();
        tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_alu_result_serializer
`default_nettype wire
